adc_responder: RTL

- Synthesizable model of the external 8-bit parallel ADC, acting as the responder end of the convert/busy/read handshake used by the PMIC PWM controller.
- Responds to a convert-start pulse by raising busy, captures a sample, then drives the result while read/chip-select is low.
- Used on-chip for loopback demos and as the DUT-side partner in closed-loop PWM regulation benches.

---
 rtl/adc_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/adc_responder.sv
// Responder end of the 8-bit parallel ADC convert/busy/read handshake.
// Define ADC_RESP_DITHER_EN to add LFSR dither (saturating) to each result.
module adc_responder #(
    parameter int unsigned BUSY_DELAY   = 2,
    parameter int unsigned CONV_CYCLES  = 20,
    parameter int unsigned ACCESS_DELAY = 1,
    parameter logic [7:0]  IDLE_VALUE   = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       conv_start,
    input  logic       rd_cs,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       busy,
    output logic [7:0] adc_data,
    output logic       data_oe,
    output logic       overrun,
    output logic [7:0] conv_count
);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StConvert,
        StDone,
        StRead
    } state_e;

    localparam int unsigned CntW = 16;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            conv_cur_q, conv_prev_q, rd_cur_q, rd_prev_q;
    logic            conv_rise, rd_fall, rd_rise, conv_done;
    logic            busy_q, busy_d, oe_q, oe_d, ovr_q, ovr_d;
    logic [7:0]      data_q, data_d, count_q, count_d;
    logic [7:0]      held_q, held_d, cap_q, cap_d, result_q, result_d;
    logic [7:0]      next_result;

    assign conv_rise = conv_cur_q & ~conv_prev_q;
    assign rd_fall   = ~rd_cur_q & rd_prev_q;
    assign rd_rise   = rd_cur_q & ~rd_prev_q;
    assign conv_done = (state_q == StConvert) && (cnt_q == CntW'(CONV_CYCLES - 1));

`ifdef ADC_RESP_DITHER_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [8:0] dither_sum;

    assign dither_sum  = {1'b0, cap_q} + {7'd0, lfsr_q[1:0]};
    assign next_result = dither_sum[8] ? 8'hFF : dither_sum[7:0];

    // x^8+x^6+x^5+x^4+1, stepped once per finished conversion
    always_comb begin
        lfsr_d = lfsr_q;
        if (conv_done) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign next_result = cap_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        oe_d     = oe_q;
        data_d   = data_q;
        ovr_d    = ovr_q;
        count_d  = count_q;
        cap_d    = cap_q;
        result_d = result_q;
        held_d   = held_q;

        if (sample_valid && sample_ready) begin
            held_d = sample_in;
        end

        unique case (state_q)
            StIdle: begin
                if (rd_fall) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end else if (conv_rise) begin
                    state_d = StArm;
                    cnt_d   = '0;
                end
            end
            StArm: begin
                if (conv_rise) ovr_d = 1'b1;
                if (cnt_q == CntW'(BUSY_DELAY - 1)) begin
                    // Capture the value held before this edge; a same-cycle write is too late.
                    state_d = StConvert;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    cap_d   = held_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StConvert: begin
                if (conv_rise) ovr_d = 1'b1;
                if (conv_done) begin
                    state_d  = StDone;
                    busy_d   = 1'b0;
                    result_d = next_result;
                    count_d  = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (rd_fall) begin
                    state_d = StRead;
                    cnt_d   = '0;
                    if (conv_rise) ovr_d = 1'b1;
                end else if (conv_rise) begin
                    state_d = StArm;
                    cnt_d   = '0;
                    ovr_d   = 1'b1;
                end
            end
            StRead: begin
                if (conv_rise) ovr_d = 1'b1;
                if (rd_rise) begin
                    state_d = StIdle;
                    oe_d    = 1'b0;
                    data_d  = IDLE_VALUE;
                end else if (!oe_q) begin
                    if (cnt_q == CntW'(ACCESS_DELAY - 1)) begin
                        oe_d   = 1'b1;
                        data_d = result_q;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            conv_cur_q  <= 1'b0;
            conv_prev_q <= 1'b0;
            rd_cur_q    <= 1'b1;
            rd_prev_q   <= 1'b1;
            busy_q      <= 1'b0;
            oe_q        <= 1'b0;
            data_q      <= IDLE_VALUE;
            ovr_q       <= 1'b0;
            count_q     <= 8'd0;
            held_q      <= 8'd0;
            cap_q       <= 8'd0;
            result_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            conv_cur_q  <= conv_start;
            conv_prev_q <= conv_cur_q;
            rd_cur_q    <= rd_cs;
            rd_prev_q   <= rd_cur_q;
            busy_q      <= busy_d;
            oe_q        <= oe_d;
            data_q      <= data_d;
            ovr_q       <= ovr_d;
            count_q     <= count_d;
            held_q      <= held_d;
            cap_q       <= cap_d;
            result_q    <= result_d;
        end
    end

    assign sample_ready = (state_q != StConvert);
    assign busy         = busy_q;
    assign adc_data     = data_q;
    assign data_oe      = oe_q;
    assign overrun      = ovr_q;
    assign conv_count   = count_q;

endmodule
